// File: rtl/stack_seq_pkg.sv
// rtl/stack_seq_pkg.sv - opcodes, FSM state encodings and opcode class helpers for the stack sequencer
package stack_seq_pkg;

  localparam logic [2:0] OP_PUSHI = 3'b000;
  localparam logic [2:0] OP_POP   = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_NOT   = 3'b101;
  localparam logic [2:0] OP_TOS   = 3'b110;
  localparam logic [2:0] OP_RSVD  = 3'b111;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_CHECK  = 4'd1,
    ST_POP_A  = 4'd2,
    ST_WAIT_A = 4'd3,
    ST_POP_B  = 4'd4,
    ST_WAIT_B = 4'd5,
    ST_EXEC   = 4'd6,
    ST_PUSH_R = 4'd7,
    ST_DONE   = 4'd8
  } state_t;

  function automatic logic is_binary(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
  endfunction

  function automatic logic is_unary(input logic [2:0] op);
    return (op == OP_NOT) || (op == OP_POP) || (op == OP_TOS);
  endfunction

endpackage

// File: rtl/stack_seq_alu.sv
// rtl/stack_seq_alu.sv - combinational ALU; a is the top of stack, b the word beneath it
module stack_seq_alu
  import stack_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = a;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = b - a;
      OP_AND:  y = a & b;
      OP_NOT:  y = ~a;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/stack_op_sequencer.sv
// rtl/stack_op_sequencer.sv - sequences one stack instruction per start/done handshake onto the stack strobes
module stack_op_sequencer
  import stack_seq_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] imm,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [CW-1:0]    count,
  output logic             stk_push,
  output logic             stk_pop,
  output logic             stk_tos,
  output logic [WIDTH-1:0] stk_din,
  input  logic [WIDTH-1:0] stk_dout
);

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] alu_y;
  logic             check_fail;

  stack_seq_alu #(.WIDTH(WIDTH)) u_alu (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (alu_y)
  );

  // Occupancy is checked before any strobe, so count can never wrap.
  always_comb begin
    check_fail = 1'b0;
    if (op_q == OP_RSVD)                                 check_fail = 1'b1;
    else if (is_binary(op_q) && (int'(count_q) < 2))     check_fail = 1'b1;
    else if (is_unary(op_q) && (int'(count_q) < 1))      check_fail = 1'b1;
    else if ((op_q == OP_PUSHI) && (int'(count_q) == DEPTH)) check_fail = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    imm_d    = imm_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    err_d    = err_q;
    count_d  = count_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = opcode;
          imm_d   = imm;
          err_d   = 1'b0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (check_fail) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (op_q == OP_PUSHI) begin
          result_d = imm_q;
          state_d  = ST_PUSH_R;
        end else begin
          state_d = ST_POP_A;
        end
      end
      ST_POP_A: begin
        if (op_q != OP_TOS) count_d = count_q - CW'(1);
        state_d = ST_WAIT_A;
      end
      ST_WAIT_A: begin
        a_d = stk_dout;
        if ((op_q == OP_POP) || (op_q == OP_TOS)) begin
          result_d = stk_dout;
          state_d  = ST_DONE;
        end else if (op_q == OP_NOT) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_POP_B;
        end
      end
      ST_POP_B: begin
        count_d = count_q - CW'(1);
        state_d = ST_WAIT_B;
      end
      ST_WAIT_B: begin
        b_d     = stk_dout;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        result_d = alu_y;
        state_d  = ST_PUSH_R;
      end
      ST_PUSH_R: begin
        count_d = count_q + CW'(1);
        state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_PUSHI;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      imm_q    <= imm_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      err_q    <= err_d;
      count_q  <= count_d;
    end
  end

  // Strobes decode straight from state, so reset drops any in-flight strobe at once.
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign err      = err_q;
  assign result   = result_q;
  assign count    = count_q;
  assign stk_push = (state_q == ST_PUSH_R);
  assign stk_pop  = ((state_q == ST_POP_A) && (op_q != OP_TOS)) || (state_q == ST_POP_B);
  assign stk_tos  = (state_q == ST_POP_A) && (op_q == OP_TOS);
  assign stk_din  = stk_push ? result_q : '0;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// tb/tb_stack_op_sequencer.sv - directed table-driven bench for stack_op_sequencer with a behavioural stack
module tb_stack_op_sequencer;
  import stack_seq_pkg::*;

  localparam int W = 8;
  localparam int D = 4;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [2:0]    opcode;
  logic [W-1:0]  imm;
  logic          busy, done, err;
  logic [W-1:0]  result;
  logic [CW-1:0] count;
  logic          stk_push, stk_pop, stk_tos;
  logic [W-1:0]  stk_din;
  logic [W-1:0]  stk_dout = '0;

  int checks = 0;
  int errors = 0;
  int multi  = 0;

  always #5 clk = ~clk;

  stack_op_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .imm(imm),
    .busy(busy), .done(done), .err(err), .result(result), .count(count),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_tos(stk_tos),
    .stk_din(stk_din), .stk_dout(stk_dout)
  );

  // Behavioural stack: d_out is valid the cycle after a pop/tos strobe.
  logic [W-1:0] mem [0:7];
  int sp;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= 0;
    end else begin
      if (stk_push) begin
        mem[sp] <= stk_din;
        sp <= sp + 1;
      end
      if (stk_pop) begin
        stk_dout <= mem[sp-1];
        sp <= sp - 1;
      end
      if (stk_tos) stk_dout <= mem[sp-1];
    end
  end

  typedef struct {
    logic [2:0] op;
    logic [7:0] imm;
    logic [7:0] res;
    logic       err;
    int         cnt;
    int         lat;
    int         npush;
    logic [7:0] din;
    int         nrd;
  } vec_t;

  vec_t v [31];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [7:0] im, output int lat,
                        output logic e, output logic [7:0] r, output int npush,
                        output int nrd, output logic [7:0] lastdin);
    logic found;
    found = 1'b0; lat = 0; npush = 0; nrd = 0; lastdin = '0; e = 1'b0; r = '0;
    @(negedge clk);
    start = 1'b1; opcode = op; imm = im;
    @(posedge clk); #1;
    start = 1'b0;
    while (!found && lat < 20) begin
      lat++;
      if (int'(stk_push) + int'(stk_pop) + int'(stk_tos) > 1) multi++;
      if (stk_push) begin npush++; lastdin = stk_din; end
      if (stk_pop || stk_tos) nrd++;
      if (done) begin
        found = 1'b1; e = err; r = result;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!found) lat = -1;
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, npush, nrd, ndone;
    logic e;
    logic [7:0] r, din;

    v[0]  = '{OP_PUSHI, 8'h80, 8'h80, 1'b0, 1, 3, 1, 8'h80, 0};
    v[1]  = '{OP_PUSHI, 8'h55, 8'h55, 1'b0, 2, 3, 1, 8'h55, 0};
    v[2]  = '{OP_ADD,   8'h00, 8'hD5, 1'b0, 1, 8, 1, 8'hD5, 2};
    v[3]  = '{OP_POP,   8'h00, 8'hD5, 1'b0, 0, 4, 0, 8'h00, 1};
    v[4]  = '{OP_PUSHI, 8'h10, 8'h10, 1'b0, 1, 3, 1, 8'h10, 0};
    v[5]  = '{OP_PUSHI, 8'h03, 8'h03, 1'b0, 2, 3, 1, 8'h03, 0};
    v[6]  = '{OP_SUB,   8'h00, 8'h0D, 1'b0, 1, 8, 1, 8'h0D, 2};
    v[7]  = '{OP_PUSHI, 8'hF0, 8'hF0, 1'b0, 2, 3, 1, 8'hF0, 0};
    v[8]  = '{OP_PUSHI, 8'h20, 8'h20, 1'b0, 3, 3, 1, 8'h20, 0};
    v[9]  = '{OP_ADD,   8'h00, 8'h10, 1'b0, 2, 8, 1, 8'h10, 2};
    v[10] = '{OP_AND,   8'h00, 8'h00, 1'b0, 1, 8, 1, 8'h00, 2};
    v[11] = '{OP_POP,   8'h00, 8'h00, 1'b0, 0, 4, 0, 8'h00, 1};
    v[12] = '{OP_ADD,   8'h00, 8'h00, 1'b1, 0, 2, 0, 8'h00, 0};
    v[13] = '{OP_RSVD,  8'h00, 8'h00, 1'b1, 0, 2, 0, 8'h00, 0};
    v[14] = '{OP_POP,   8'h00, 8'h00, 1'b1, 0, 2, 0, 8'h00, 0};
    v[15] = '{OP_TOS,   8'h00, 8'h00, 1'b1, 0, 2, 0, 8'h00, 0};
    v[16] = '{OP_PUSHI, 8'h3C, 8'h3C, 1'b0, 1, 3, 1, 8'h3C, 0};
    v[17] = '{OP_TOS,   8'h00, 8'h3C, 1'b0, 1, 4, 0, 8'h00, 1};
    v[18] = '{OP_NOT,   8'h00, 8'hC3, 1'b0, 1, 6, 1, 8'hC3, 1};
    v[19] = '{OP_POP,   8'h00, 8'hC3, 1'b0, 0, 4, 0, 8'h00, 1};
    v[20] = '{OP_PUSHI, 8'h01, 8'h01, 1'b0, 1, 3, 1, 8'h01, 0};
    v[21] = '{OP_PUSHI, 8'h02, 8'h02, 1'b0, 2, 3, 1, 8'h02, 0};
    v[22] = '{OP_PUSHI, 8'h03, 8'h03, 1'b0, 3, 3, 1, 8'h03, 0};
    v[23] = '{OP_PUSHI, 8'h04, 8'h04, 1'b0, 4, 3, 1, 8'h04, 0};
    v[24] = '{OP_PUSHI, 8'h99, 8'h04, 1'b1, 4, 2, 0, 8'h00, 0};
    v[25] = '{OP_NOT,   8'h00, 8'hFB, 1'b0, 4, 6, 1, 8'hFB, 1};
    v[26] = '{OP_ADD,   8'h00, 8'hFE, 1'b0, 3, 8, 1, 8'hFE, 2};
    v[27] = '{OP_POP,   8'h00, 8'hFE, 1'b0, 2, 4, 0, 8'h00, 1};
    v[28] = '{OP_POP,   8'h00, 8'h02, 1'b0, 1, 4, 0, 8'h00, 1};
    v[29] = '{OP_SUB,   8'h00, 8'h02, 1'b1, 1, 2, 0, 8'h00, 0};
    v[30] = '{OP_RSVD,  8'h00, 8'h02, 1'b1, 1, 2, 0, 8'h00, 0};

    rst_n = 1'b0; start = 1'b0; opcode = '0; imm = '0;
    #12;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_err", 32'(err), 0);
    chk("reset_result", 32'(result), 0);
    chk("reset_count", 32'(count), 0);
    chk("reset_strobes", 32'({stk_push, stk_pop, stk_tos}), 0);
    chk("reset_din", 32'(stk_din), 0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 31; i++) begin
      run_op(v[i].op, v[i].imm, lat, e, r, npush, nrd, din);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(v[i].lat));
      chk($sformatf("v%0d_err", i), 32'(e), 32'(v[i].err));
      chk($sformatf("v%0d_result", i), 32'(r), 32'(v[i].res));
      chk($sformatf("v%0d_count", i), 32'(count), 32'(v[i].cnt));
      chk($sformatf("v%0d_pushes", i), 32'(npush), 32'(v[i].npush));
      chk($sformatf("v%0d_reads", i), 32'(nrd), 32'(v[i].nrd));
      if (v[i].npush > 0) chk($sformatf("v%0d_din", i), 32'(din), 32'(v[i].din));
    end

    // Reset asserted while ADD sits in WAIT_B.
    run_op(OP_PUSHI, 8'h11, lat, e, r, npush, nrd, din);
    @(negedge clk);
    start = 1'b1; opcode = OP_ADD;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("midrst_busy_before", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_result", 32'(result), 0);
    chk("midrst_count", 32'(count), 0);
    chk("midrst_strobes", 32'({stk_push, stk_pop, stk_tos}), 0);
    chk("midrst_din", 32'(stk_din), 0);
    @(negedge clk); rst_n = 1'b1;
    run_op(OP_PUSHI, 8'h01, lat, e, r, npush, nrd, din);
    chk("post_rst_count", 32'(count), 1);
    chk("post_rst_result", 32'(r), 32'h01);
    chk("post_rst_latency", 32'(lat), 3);

    // start held high while busy must not launch a second operation.
    ndone = 0;
    @(negedge clk);
    start = 1'b1; opcode = OP_PUSHI; imm = 8'h22;
    @(posedge clk); #1;
    opcode = OP_ADD; imm = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("busy_start_dones", 32'(ndone), 1);
    chk("busy_start_count", 32'(count), 2);
    chk("busy_start_result", 32'(result), 32'h22);
    chk("strobe_overlap", 32'(multi), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
